// File: rtl/oled_pkg.sv
// oled_pkg: opcode constants, pointer widths and decoder state type for the OLED SPI sink.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package oled_pkg;

   localparam int PAGE_W = 3;   // page field of the B0-B7 opcode
   localparam int COL_W  = 7;   // 128 columns

   localparam logic [7:0] OP_PAGE_BASE = 8'hB0;
   localparam logic [7:0] OP_COL_LO    = 8'h00;
   localparam logic [7:0] OP_COL_HI    = 8'h10;
   localparam logic [7:0] OP_CONTRAST  = 8'h81;
   localparam logic [7:0] OP_DISP_OFF  = 8'hAE;
   localparam logic [7:0] OP_DISP_ON   = 8'hAF;
   localparam logic [7:0] CONTRAST_RST = 8'h7F;

   typedef enum logic {
      DEC_CMD = 1'b0,
      DEC_ARG = 1'b1
   } dec_state_t;

   // Opcodes that are followed by exactly one argument byte.
   function automatic logic takes_arg(input logic [7:0] op);
      case (op)
         8'h81, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB, 8'h8D: takes_arg = 1'b1;
         default:                                                takes_arg = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/oled_spi_sink_if.sv
// oled_spi_sink_if: 4-wire write-only OLED SPI bus (chip select, serial clock, D/C, data).
// Latency: n/a (wires only).
// Backpressure: none; the bus is driven unconditionally by the master.
// Ports: oled_csn (active low), oled_clk (rising-edge sampled), oled_dcn (1=data), oled_dat (MSB first).
interface oled_spi_sink_if;
   logic oled_csn;
   logic oled_clk;
   logic oled_dcn;
   logic oled_dat;

   modport master (output oled_csn, output oled_clk, output oled_dcn, output oled_dat);
   modport slave  (input  oled_csn, input  oled_clk, input  oled_dcn, input  oled_dat);
endinterface

// File: rtl/oled_spi_shift.sv
// oled_spi_shift: synchronizes the SPI pins, detects serial clock rises and assembles bytes.
// Latency: byte_valid is registered, SYNC_STAGES+1 clk after the 8th raw clock high reaches the pins.
// Backpressure: none; every completed byte is presented for exactly one cycle.
// Ports: clk/rst; raw csn/sclk/dcn/dat in; byte_valid, byte_data, byte_dc, frame_err out.
module oled_spi_shift #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       csn_in,
   input  logic       sclk_in,
   input  logic       dcn_in,
   input  logic       dat_in,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       byte_dc,
   output logic       frame_err
);

   logic [SYNC_STAGES-1:0] csn_sync, sclk_sync, dcn_sync, dat_sync;
   logic       csn_s, sclk_s, dcn_s, dat_s;
   logic       sclk_prev;
   logic       rise;
   logic [2:0] bit_cnt;
   logic [7:0] shreg;
   logic [7:0] shreg_nxt;

   assign csn_s     = csn_sync[SYNC_STAGES-1];
   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign dcn_s     = dcn_sync[SYNC_STAGES-1];
   assign dat_s     = dat_sync[SYNC_STAGES-1];
   assign rise      = sclk_s & ~sclk_prev;
   assign shreg_nxt = {shreg[6:0], dat_s};

   // All four pins go through the same depth so they stay mutually aligned.
   // Reset parks the bus as idle (deselected, clock low).
   always_ff @(posedge clk) begin
      if (rst) begin
         csn_sync  <= '1;
         sclk_sync <= '0;
         dcn_sync  <= '0;
         dat_sync  <= '0;
      end else begin
         csn_sync[0]  <= csn_in;
         sclk_sync[0] <= sclk_in;
         dcn_sync[0]  <= dcn_in;
         dat_sync[0]  <= dat_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            csn_sync[i]  <= csn_sync[i-1];
            sclk_sync[i] <= sclk_sync[i-1];
            dcn_sync[i]  <= dcn_sync[i-1];
            dat_sync[i]  <= dat_sync[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_prev  <= 1'b0;
         bit_cnt    <= '0;
         shreg      <= '0;
         byte_valid <= 1'b0;
         byte_data  <= '0;
         byte_dc    <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         sclk_prev  <= sclk_s;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         // An 8th edge coinciding with CSN rising still completes the byte.
         if (rise && (!csn_s || bit_cnt == 3'd7)) begin
            shreg   <= shreg_nxt;
            bit_cnt <= bit_cnt + 3'd1;   // 7 -> 0 wraps on completion
            if (bit_cnt == 3'd7) begin
               byte_valid <= 1'b1;
               byte_data  <= shreg_nxt;
               byte_dc    <= dcn_s;
            end
         end else if (csn_s) begin
            bit_cnt <= '0;
            if (bit_cnt != 3'd0) frame_err <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/oled_spi_sink.sv
// oled_spi_sink: SSD1306-style command/data decoder mirroring the OLED serial link into frame-buffer writes.
// Latency: strobes are registered, SYNC_STAGES+2 clk after the 8th raw oled_clk high; frame_err SYNC_STAGES+1 after CSN rise.
// Backpressure: none; a byte every 16 clk or faster is accepted without stalls.
// Ports: clk/rst; spi (slave bus); fb_we/fb_addr/fb_wdata writes; cmd_valid/cmd_byte; disp_on, contrast; frame_err, oob_err.
module oled_spi_sink
   import oled_pkg::*;
#(
   parameter int PAGES       = 4,
   parameter int COLS        = 128,
   parameter int SYNC_STAGES = 2
) (
   input  logic           clk,
   input  logic           rst,
   oled_spi_sink_if.slave spi,
   output logic           fb_we,
   output logic [8:0]     fb_addr,
   output logic [7:0]     fb_wdata,
   output logic           cmd_valid,
   output logic [7:0]     cmd_byte,
   output logic           disp_on,
   output logic [7:0]     contrast,
   output logic           frame_err,
   output logic           oob_err
);

   localparam logic [PAGE_W:0]  PAGE_LIM = (PAGE_W + 1)'(PAGES);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
   localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);

   logic       byte_valid, byte_dc;
   logic [7:0] byte_data;

   oled_spi_shift #(.SYNC_STAGES(SYNC_STAGES)) u_shift (
      .clk        (clk),
      .rst        (rst),
      .csn_in     (spi.oled_csn),
      .sclk_in    (spi.oled_clk),
      .dcn_in     (spi.oled_dcn),
      .dat_in     (spi.oled_dat),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_dc    (byte_dc),
      .frame_err  (frame_err)
   );

   dec_state_t        state, state_nxt;
   logic [PAGE_W-1:0] page, page_d;
   logic [COL_W-1:0]  col, col_d;
   logic [7:0]        arg_op, arg_op_d;
   logic              we_d, oob_d, cv_d, disp_d;
   logic [8:0]        addr_d;
   logic [7:0]        wdata_d, cbyte_d, contrast_d;

   always_ff @(posedge clk) begin
      if (rst) state <= DEC_CMD;
      else     state <= state_nxt;
   end

   // Data bytes always abandon a pending argument.
   always_comb begin
      state_nxt = state;
      if (byte_valid) begin
         if (byte_dc || state == DEC_ARG) state_nxt = DEC_CMD;
         else if (takes_arg(byte_data))   state_nxt = DEC_ARG;
      end
   end

   always_comb begin
      page_d     = page;
      col_d      = col;
      arg_op_d   = arg_op;
      disp_d     = disp_on;
      contrast_d = contrast;
      we_d       = 1'b0;
      oob_d      = 1'b0;
      cv_d       = 1'b0;
      addr_d     = fb_addr;
      wdata_d    = fb_wdata;
      cbyte_d    = cmd_byte;
      if (byte_valid) begin
         if (byte_dc) begin
            if ({1'b0, page} < PAGE_LIM) begin
               we_d    = 1'b1;
               addr_d  = {page[1:0], col};
               wdata_d = byte_data;
            end else begin
               oob_d = 1'b1;
            end
            // Column advances even on an out-of-range page, page never does.
            col_d = (col == COL_LAST) ? '0 : col + COL_ONE;
         end else begin
            cv_d    = 1'b1;
            cbyte_d = byte_data;
            if (state == DEC_ARG) begin
               if (arg_op == OP_CONTRAST) contrast_d = byte_data;
            end else begin
               if (byte_data[7:3] == OP_PAGE_BASE[7:3])    page_d     = byte_data[2:0];
               else if (byte_data[7:4] == OP_COL_LO[7:4])  col_d[3:0] = byte_data[3:0];
               else if (byte_data[7:4] == OP_COL_HI[7:4])  col_d[6:4] = byte_data[2:0];
               else if (byte_data == OP_DISP_OFF)          disp_d     = 1'b0;
               else if (byte_data == OP_DISP_ON)           disp_d     = 1'b1;
               if (takes_arg(byte_data)) arg_op_d = byte_data;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         page      <= '0;
         col       <= '0;
         arg_op    <= '0;
         disp_on   <= 1'b0;
         contrast  <= CONTRAST_RST;
         fb_we     <= 1'b0;
         oob_err   <= 1'b0;
         cmd_valid <= 1'b0;
         fb_addr   <= '0;
         fb_wdata  <= '0;
         cmd_byte  <= '0;
      end else begin
         page      <= page_d;
         col       <= col_d;
         arg_op    <= arg_op_d;
         disp_on   <= disp_d;
         contrast  <= contrast_d;
         fb_we     <= we_d;
         oob_err   <= oob_d;
         cmd_valid <= cv_d;
         fb_addr   <= addr_d;
         fb_wdata  <= wdata_d;
         cmd_byte  <= cbyte_d;
      end
   end

endmodule

// File: tb/tb_oled_spi_sink.sv
// tb_oled_spi_sink: directed scenarios plus a randomized byte stream checked against a behavioural model.
// Latency: strobe timing is measured against the moment the bench raises the 8th serial clock.
// Backpressure: n/a.
module tb_oled_spi_sink;

   localparam int SYNC  = 2;
   localparam int PAGES = 4;
   localparam int COLS  = 128;

   logic       clk;
   logic       rst;
   logic       fb_we, cmd_valid, disp_on, frame_err, oob_err;
   logic [8:0] fb_addr;
   logic [7:0] fb_wdata, cmd_byte, contrast;

   oled_spi_sink_if spi_bus();

   oled_spi_sink #(.PAGES(PAGES), .COLS(COLS), .SYNC_STAGES(SYNC)) dut (
      .clk       (clk),
      .rst       (rst),
      .spi       (spi_bus),
      .fb_we     (fb_we),
      .fb_addr   (fb_addr),
      .fb_wdata  (fb_wdata),
      .cmd_valid (cmd_valid),
      .cmd_byte  (cmd_byte),
      .disp_on   (disp_on),
      .contrast  (contrast),
      .frame_err (frame_err),
      .oob_err   (oob_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_tests = 0;
   int n_fail  = 0;

   // Observed events, gathered on the falling edge.
   int neg_cnt = 0;
   int obs_addr[$];
   int obs_data[$];
   int obs_cmd[$];
   int obs_oob = 0, obs_ferr = 0;
   int last_we_cyc = 0, last_cmd_cyc = 0, last_ferr_cyc = 0;
   int t_hi = 0, t_csn = 0;

   always @(negedge clk) begin
      neg_cnt = neg_cnt + 1;
      if (fb_we) begin
         obs_addr.push_back(int'(fb_addr));
         obs_data.push_back(int'(fb_wdata));
         last_we_cyc = neg_cnt;
      end
      if (cmd_valid) begin
         obs_cmd.push_back(int'(cmd_byte));
         last_cmd_cyc = neg_cnt;
      end
      if (oob_err) obs_oob = obs_oob + 1;
      if (frame_err) begin
         obs_ferr = obs_ferr + 1;
         last_ferr_cyc = neg_cnt;
      end
   end

   task automatic clear_obs();
      obs_addr.delete();
      obs_data.delete();
      obs_cmd.delete();
      obs_oob  = 0;
      obs_ferr = 0;
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drives nbits of b MSB first. csn_on_last raises CSN together with the last clock rise.
   task automatic send_bits(input logic dc, input logic [7:0] b, input int nbits,
                            input bit csn_on_last, input bit raise_csn);
      spi_bus.oled_csn = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         spi_bus.oled_clk = 1'b0;
         spi_bus.oled_dat = b[7-i];
         spi_bus.oled_dcn = dc;
         wait_cyc($urandom_range(1, 2));
         spi_bus.oled_clk = 1'b1;
         if (csn_on_last && i == nbits - 1) spi_bus.oled_csn = 1'b1;
         t_hi = neg_cnt;
         wait_cyc($urandom_range(1, 2));
      end
      spi_bus.oled_clk = 1'b0;
      wait_cyc(1);
      if (raise_csn) begin
         spi_bus.oled_csn = 1'b1;
         t_csn = neg_cnt;
         wait_cyc(1);
      end
   endtask

   // Behavioural model: display state as plain integers, expected events as queues.
   int  m_page, m_col, m_contrast, m_pend;
   bit  m_disp;
   int  exp_addr[$];
   int  exp_data[$];
   int  exp_cmd[$];
   int  exp_oob;

   task automatic model_reset();
      m_page = 0; m_col = 0; m_contrast = 'h7F; m_pend = -1; m_disp = 1'b0;
      exp_addr.delete(); exp_data.delete(); exp_cmd.delete(); exp_oob = 0;
   endtask

   task automatic model_byte(input bit dc, input int b);
      if (dc) begin
         if (m_page < PAGES) begin
            exp_addr.push_back((m_page % 4) * 128 + m_col);
            exp_data.push_back(b);
         end else begin
            exp_oob = exp_oob + 1;
         end
         m_col  = (m_col + 1) % COLS;
         m_pend = -1;
      end else begin
         exp_cmd.push_back(b);
         if (m_pend >= 0) begin
            if (m_pend == 'h81) m_contrast = b;
            m_pend = -1;
         end else begin
            if (b >= 'hB0 && b <= 'hB7)  m_page = b - 'hB0;
            else if (b < 16)             m_col  = (m_col / 16) * 16 + b;
            else if (b < 32)             m_col  = ((b - 16) % 8) * 16 + (m_col % 16);
            else if (b == 'hAE)          m_disp = 1'b0;
            else if (b == 'hAF)          m_disp = 1'b1;
            if (b == 'h81 || b == 'hA8 || b == 'hD3 || b == 'hD5 || b == 'hD9 ||
                b == 'hDA || b == 'hDB || b == 'h8D) m_pend = b;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      spi_bus.oled_csn = 1'b1; spi_bus.oled_clk = 1'b0;
      spi_bus.oled_dcn = 1'b0; spi_bus.oled_dat = 1'b0;
      wait_cyc(3);
      n_tests++;
      if ({fb_we, cmd_valid, frame_err, oob_err, disp_on} !== 5'b0) begin
         n_fail++; $display("FAIL reset_flags: got %b want 00000", {fb_we, cmd_valid, frame_err, oob_err, disp_on});
      end
      n_tests++;
      if ({fb_addr, fb_wdata, cmd_byte} !== 25'h0) begin
         n_fail++; $display("FAIL reset_buses: got addr %h wdata %h cmd %h want 0", fb_addr, fb_wdata, cmd_byte);
      end
      n_tests++;
      if (contrast !== 8'h7F) begin
         n_fail++; $display("FAIL reset_contrast: got %h want 7f", contrast);
      end
      rst = 1'b0;
      wait_cyc(SYNC + 4);
      clear_obs();
   endtask

   task automatic test_disp_on();
      send_bits(1'b0, 8'hAF, 8, 1'b0, 1'b1);
      wait_cyc(SYNC + 6);
      n_tests++;
      if (obs_cmd.size() !== 1 || obs_cmd[0] !== 'hAF) begin
         n_fail++; $display("FAIL disp_on_cmd: got %0d strobes first %h want 1 strobe af",
                            obs_cmd.size(), (obs_cmd.size() > 0) ? obs_cmd[0] : -1);
      end
      n_tests++;
      if (disp_on !== 1'b1 || contrast !== 8'h7F) begin
         n_fail++; $display("FAIL disp_on_state: got disp %b contrast %h want 1 7f", disp_on, contrast);
      end
      n_tests++;
      if (last_cmd_cyc !== t_hi + SYNC + 3) begin
         n_fail++; $display("FAIL cmd_latency: got cycle %0d want %0d", last_cmd_cyc, t_hi + SYNC + 3);
      end
      clear_obs();
   endtask

   task automatic test_data_write();
      send_bits(1'b0, 8'hB0, 8, 1'b0, 1'b1);
      send_bits(1'b0, 8'h00, 8, 1'b0, 1'b0);
      send_bits(1'b0, 8'h16, 8, 1'b0, 1'b1);
      send_bits(1'b1, 8'h3E, 8, 1'b0, 1'b0);
      send_bits(1'b1, 8'h51, 8, 1'b0, 1'b1);
      wait_cyc(SYNC + 6);
      n_tests++;
      if (obs_addr.size() !== 2 || obs_cmd.size() !== 3) begin
         n_fail++; $display("FAIL write_count: got %0d writes %0d cmds want 2 and 3", obs_addr.size(), obs_cmd.size());
      end else begin
         n_tests++;
         if (obs_addr[0] !== 'h060 || obs_addr[1] !== 'h061 || obs_data[0] !== 'h3E || obs_data[1] !== 'h51) begin
            n_fail++; $display("FAIL write_values: got %h/%h %h/%h want 060/3e 061/51",
                               obs_addr[0], obs_data[0], obs_addr[1], obs_data[1]);
         end
      end
      n_tests++;
      if (last_we_cyc !== t_hi + SYNC + 3) begin
         n_fail++; $display("FAIL write_latency: got cycle %0d want %0d", last_we_cyc, t_hi + SYNC + 3);
      end
      clear_obs();
   endtask

   task automatic test_col_wrap();
      send_bits(1'b0, 8'hB1, 8, 1'b0, 1'b0);
      send_bits(1'b0, 8'h0F, 8, 1'b0, 1'b0);
      send_bits(1'b0, 8'h17, 8, 1'b0, 1'b1);
      send_bits(1'b1, 8'hAA, 8, 1'b0, 1'b1);
      send_bits(1'b1, 8'hBB, 8, 1'b0, 1'b1);
      wait_cyc(SYNC + 6);
      n_tests++;
      if (obs_addr.size() !== 2) begin
         n_fail++; $display("FAIL wrap_count: got %0d writes want 2", obs_addr.size());
      end else begin
         n_tests++;
         if (obs_addr[0] !== 'h0FF || obs_addr[1] !== 'h080 || obs_data[0] !== 'hAA || obs_data[1] !== 'hBB) begin
            n_fail++; $display("FAIL wrap_values: got %h/%h %h/%h want 0ff/aa 080/bb",
                               obs_addr[0], obs_data[0], obs_addr[1], obs_data[1]);
         end
      end
      clear_obs();
   endtask

   task automatic test_contrast();
      send_bits(1'b0, 8'h81, 8, 1'b0, 1'b1);
      send_bits(1'b0, 8'h40, 8, 1'b0, 1'b1);
      wait_cyc(SYNC + 6);
      n_tests++;
      if (obs_cmd.size() !== 2 || contrast !== 8'h40) begin
         n_fail++; $display("FAIL contrast_set: got %0d cmds contrast %h want 2 cmds 40", obs_cmd.size(), contrast);
      end
      clear_obs();
      send_bits(1'b0, 8'h81, 8, 1'b0, 1'b1);
      send_bits(1'b1, 8'h11, 8, 1'b0, 1'b1);
      wait_cyc(SYNC + 6);
      n_tests++;
      if (obs_addr.size() !== 1 || contrast !== 8'h40 ||
          ((obs_addr.size() > 0) ? (obs_addr[0] * 256 + obs_data[0]) : -1) !== 'h08111) begin
         n_fail++; $display("FAIL arg_abandon: got %0d writes first %h contrast %h want 1 write 081/11 contrast 40",
                            obs_addr.size(), (obs_addr.size() > 0) ? obs_addr[0] : -1, contrast);
      end
      send_bits(1'b0, 8'h81, 8, 1'b0, 1'b1);
      send_bits(1'b0, 8'h55, 8, 1'b0, 1'b1);
      wait_cyc(SYNC + 6);
      n_tests++;
      if (contrast !== 8'h55) begin
         n_fail++; $display("FAIL opcode_after_data: got contrast %h want 55", contrast);
      end
      clear_obs();
   endtask

   task automatic test_frame_err();
      send_bits(1'b0, 8'hFF, 5, 1'b0, 1'b1);
      wait_cyc(SYNC + 6);
      n_tests++;
      if (obs_ferr !== 1 || obs_cmd.size() !== 0 || obs_addr.size() !== 0) begin
         n_fail++; $display("FAIL frame_err_pulse: got %0d pulses %0d cmds %0d writes want 1 0 0",
                            obs_ferr, obs_cmd.size(), obs_addr.size());
      end
      n_tests++;
      if (last_ferr_cyc !== t_csn + SYNC + 2) begin
         n_fail++; $display("FAIL frame_err_latency: got cycle %0d want %0d", last_ferr_cyc, t_csn + SYNC + 2);
      end
      send_bits(1'b0, 8'hB2, 8, 1'b0, 1'b1);
      send_bits(1'b1, 8'h01, 8, 1'b0, 1'b1);
      wait_cyc(SYNC + 6);
      n_tests++;
      if (obs_cmd.size() !== 1 || obs_addr.size() !== 1 ||
          ((obs_addr.size() > 0) ? obs_addr[0] : -1) !== 'h102) begin
         n_fail++; $display("FAIL after_frame_err: got %0d cmds %0d writes addr %h want 1 1 102",
                            obs_cmd.size(), obs_addr.size(), (obs_addr.size() > 0) ? obs_addr[0] : -1);
      end
      // CSN rising together with the 8th clock edge must complete the byte.
      send_bits(1'b0, 8'hAE, 8, 1'b1, 1'b1);
      wait_cyc(SYNC + 6);
      n_tests++;
      if (obs_ferr !== 1 || obs_cmd.size() !== 2 || disp_on !== 1'b0) begin
         n_fail++; $display("FAIL csn_with_last_edge: got %0d err pulses %0d cmds disp %b want 1 2 0",
                            obs_ferr, obs_cmd.size(), disp_on);
      end
      clear_obs();
   endtask

   task automatic test_oob_and_rst();
      send_bits(1'b0, 8'hB5, 8, 1'b0, 1'b1);
      send_bits(1'b1, 8'hFF, 8, 1'b0, 1'b1);
      send_bits(1'b0, 8'hAF, 8, 1'b0, 1'b1);
      wait_cyc(SYNC + 6);
      n_tests++;
      if (obs_oob !== 1 || obs_addr.size() !== 0 || disp_on !== 1'b1) begin
         n_fail++; $display("FAIL oob: got %0d oob %0d writes disp %b want 1 0 1", obs_oob, obs_addr.size(), disp_on);
      end
      clear_obs();
      send_bits(1'b1, 8'hC3, 3, 1'b0, 1'b0);
      rst = 1'b1;
      spi_bus.oled_csn = 1'b1;
      spi_bus.oled_clk = 1'b0;
      wait_cyc(1);
      n_tests++;
      if ({fb_we, cmd_valid, frame_err, oob_err, disp_on, fb_addr, fb_wdata, cmd_byte, contrast} !==
          {5'b0, 9'h0, 8'h00, 8'h00, 8'h7F}) begin
         n_fail++; $display("FAIL mid_byte_rst: got disp %b contrast %h cmd %h addr %h want 0 7f 00 000",
                            disp_on, contrast, cmd_byte, fb_addr);
      end
      rst = 1'b0;
      wait_cyc(SYNC + 6);
      n_tests++;
      if (obs_ferr !== 0) begin
         n_fail++; $display("FAIL rst_no_frame_err: got %0d pulses want 0", obs_ferr);
      end
      send_bits(1'b1, 8'h77, 8, 1'b0, 1'b1);
      wait_cyc(SYNC + 6);
      n_tests++;
      if (obs_addr.size() !== 1 || ((obs_addr.size() > 0) ? (obs_addr[0] * 256 + obs_data[0]) : -1) !== 'h00077) begin
         n_fail++; $display("FAIL rst_pointers: got %0d writes addr %h want 1 write 000/77",
                            obs_addr.size(), (obs_addr.size() > 0) ? obs_addr[0] : -1);
      end
      clear_obs();
   endtask

   task automatic test_random();
      int  r, b;
      bit  dc;
      int  nmin;
      rst = 1'b1;
      wait_cyc(2);
      rst = 1'b0;
      wait_cyc(SYNC + 4);
      clear_obs();
      model_reset();
      for (int k = 0; k < 60; k++) begin
         r  = $urandom_range(0, 9);
         dc = (r <= 3);
         case (r)
            0, 1, 2, 3: b = $urandom_range(0, 255);
            4:          b = 'hB0 + $urandom_range(0, 7);
            5:          b = $urandom_range(0, 31);
            6:          b = ($urandom_range(0, 1) == 1) ? 'hAF : 'hAE;
            7:          b = 'h81;
            8:          b = ($urandom_range(0, 1) == 1) ? 'hA8 : 'h8D;
            default:    b = $urandom_range(0, 255);
         endcase
         model_byte(dc, b);
         send_bits(dc, 8'(b), 8, 1'b0, (k == 59) || ($urandom_range(0, 1) == 1));
      end
      wait_cyc(SYNC + 6);
      n_tests++;
      if (obs_addr.size() !== exp_addr.size() || obs_cmd.size() !== exp_cmd.size() || obs_oob !== exp_oob) begin
         n_fail++; $display("FAIL rand_counts: got %0d/%0d/%0d writes/cmds/oob want %0d/%0d/%0d",
                            obs_addr.size(), obs_cmd.size(), obs_oob, exp_addr.size(), exp_cmd.size(), exp_oob);
      end
      nmin = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
      for (int i = 0; i < nmin; i++) begin
         n_tests++;
         if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
            n_fail++; $display("FAIL rand_write[%0d]: got %h/%h want %h/%h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
         end
      end
      nmin = (obs_cmd.size() < exp_cmd.size()) ? obs_cmd.size() : exp_cmd.size();
      for (int i = 0; i < nmin; i++) begin
         n_tests++;
         if (obs_cmd[i] !== exp_cmd[i]) begin
            n_fail++; $display("FAIL rand_cmd[%0d]: got %h want %h", i, obs_cmd[i], exp_cmd[i]);
         end
      end
      n_tests++;
      if (disp_on !== m_disp || int'(contrast) !== m_contrast || obs_ferr !== 0) begin
         n_fail++; $display("FAIL rand_state: got disp %b contrast %h ferr %0d want %b %h 0",
                            disp_on, contrast, obs_ferr, m_disp, m_contrast);
      end
      clear_obs();
   endtask

   initial begin
      rst = 1'b1;
      spi_bus.oled_csn = 1'b1;
      spi_bus.oled_clk = 1'b0;
      spi_bus.oled_dcn = 1'b0;
      spi_bus.oled_dat = 1'b0;
      test_reset();
      test_disp_on();
      test_data_write();
      test_col_wrap();
      test_contrast();
      test_frame_err();
      test_oob_and_rst();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/oled_spi_sink.md
# oled_spi_sink

Receive-side model of the OLED serial link: it samples the 4-wire write-only SPI bus (`oled_csn`, `oled_clk`, `oled_dcn`, `oled_dat`) driven by the OLED driver and decodes SSD1306-style command/data bytes. It maintains page/column pointers, captures display state, and emits frame-buffer write strobes. It sits beside the driver as a loop-back checker or on-chip display mirror, all in the same `clk` domain.

## Interface
- `PAGES`, 4, number of 8-row pages (128x32 panel)
- `COLS`, 128, columns per page
- `SYNC_STAGES`, 2, input sampling register depth (≥1)
- `clk`  in  1  system clock (12 MHz)
- `rst`  in  1  reset; one clock, reset is synchronous and active-high
- `oled_csn`  in  1  chip select, active low
- `oled_clk`  in  1  serial clock, data sampled on rising edge
- `oled_dcn`  in  1  1 = data byte, 0 = command byte
- `oled_dat`  in  1  serial data, MSB first
- `fb_we`  out  1  one-cycle frame-buffer write strobe
- `fb_addr`  out  9  {page[1:0], col[6:0]}
- `fb_wdata`  out  8  column byte (bit0 = top row of page)
- `cmd_valid`  out  1  one-cycle strobe per complete command byte (opcode or argument)
- `cmd_byte`  out  8  byte accompanying `cmd_valid`
- `disp_on`  out  1  display on/off state
- `contrast`  out  8  last contrast argument
- `frame_err`  out  1  one-cycle pulse: CSN deasserted mid-byte
- `oob_err`  out  1  one-cycle pulse: data byte while page ≥ PAGES

## Operation
- Reset values: `fb_we`, `cmd_valid`, `frame_err`, `oob_err` = 0; `fb_addr` = 0; `fb_wdata`, `cmd_byte` = 0; `disp_on` = 0; `contrast` = 8'h7F; page = 0; col = 0; bit count = 0; decoder in CMD.
- All four bus inputs pass through identical `SYNC_STAGES` registers so they stay aligned. Rising edge = synced `oled_clk` high and previous sample low.
- Shifter: while synced CSN low, each rising edge shifts `oled_dat` in MSB-first, bit count +1; on 8th edge byte is complete, DC latched at that edge, count → 0.
- Synced CSN high clears bit count; if count was 1..7, pulse `frame_err`, discard partial byte. CSN rise and 8th edge in the same cycle: byte completes, no error.
- Decoder states: CMD, ARG.
  - CMD, DC=0: pulse `cmd_valid`. B0–B7 → page = byte[2:0]; 00–0F → col[3:0]; 10–1F → col[6:4] = byte[2:0]; AE → `disp_on`=0; AF → `disp_on`=1; 81, A8, D3, D5, D9, DA, DB, 8D → ARG (remember opcode); others ignored.
  - ARG, DC=0: pulse `cmd_valid`; if opcode 81, `contrast` = byte; → CMD.
  - Any state, DC=1: if page < PAGES, `fb_we`=1, `fb_addr`={page,col}, `fb_wdata`=byte; else `oob_err`, no write. Column then increments, COLS-1 wraps to 0, page unchanged. ARG is abandoned → CMD.
- Decoder state and pointers persist across CSN toggles (driver deasserts CSN between bytes).

## Timing
- Completed byte → outputs registered: strobe is high for exactly one cycle, `SYNC_STAGES`+2 clk cycles after the cycle in which the 8th raw `oled_clk` high level is first present at the input.
- `frame_err` asserts `SYNC_STAGES`+1 cycles after raw CSN rise.
- Each bus level must be held ≥1 clk; throughput up to one bit per 2 clk (driver rate).
- `rst` mid-byte: partial byte discarded, no error pulse, all state to reset values next cycle.

## Structure
- Package `oled_pkg`: opcode constants (page base B0, col-low 00, col-high 10, contrast 81, display off/on AE/AF), set of argument-taking opcodes, contrast reset 7F, page/column widths.
- Sub-module `oled_spi_shift`: synchronizer, edge detect, bit counter, shift register; outputs `byte_valid`, `byte`, `byte_dc`, `frame_err`. Top holds decoder FSM and pointers.

## Test plan
- Reset, send cmd AF → `cmd_valid` with 8'hAF, `disp_on`=1; `contrast`=8'h7F.
- Cmds B0, 00, 16, then data 3E,51 → `fb_we` twice, `fb_addr` 9'h060 then 9'h061, data 3E, 51.
- Cmds B1, 0F, 17 (col 127), data AA, BB → addr 9'h0FF then 9'h080 (wrap, page 1 kept).
- Cmd 81, arg 40 → two `cmd_valid`, `contrast`=8'h40; cmd 81 then data 11 → write occurs, contrast unchanged, next byte 81 decoded as opcode.
- CSN raised after 5 bits → `frame_err` one cycle, no strobe; following full byte B2 decoded correctly (page 2).
- Cmd B5, data FF → `oob_err`, no `fb_we`; `rst` asserted after 3 bits → outputs at reset values, no `frame_err`.
